// File: rtl/tx_iq_intf_mc_pkg.sv
// rtl/tx_iq_intf_mc_pkg.sv - shared FSM encoding, saturation bounds and slice helper for tx_iq_intf_mc
package tx_iq_intf_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_STREAM  = 2'd2
  } tx_state_t;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // part 0 selects I, part 1 selects Q; channel 0 sits at the LSB
  function automatic int iq_lsb(input int ch, input int part, input int w);
    return (2 * ch + part) * w;
  endfunction

endpackage

// File: rtl/tx_iq_mc_fifo.sv
// rtl/tx_iq_mc_fifo.sv - first-word-fall-through sync FIFO with occupancy count
module tx_iq_mc_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  push_drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (ADDR_WIDTH + 1)'(DEPTH));
  assign do_pop    = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push at full still lands
  assign do_push   = push & (~full | do_pop);
  assign push_drop = push & full & ~do_pop;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_iq_intf_mc.sv
// rtl/tx_iq_intf_mc.sv - multi-channel TX I/Q gain, buffering and DAC streaming; TX_IQ_INTF_MC_UNDERRUN_CNT_EN builds the underrun counter
module tx_iq_intf_mc
  import tx_iq_intf_mc_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int IQ_DATA_WIDTH = 16,
  parameter int GAIN_WIDTH    = 10,
  parameter int GAIN_SHIFT    = 7,
  parameter int FIFO_AW       = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] rf_iq,
  input  logic                            rf_iq_valid,
  input  logic                            tx_end,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]    bb_gain,
  input  logic [FIFO_AW:0]                hold_hi,
  input  logic [FIFO_AW:0]                hold_lo,
  input  logic [FIFO_AW:0]                prefill_thresh,
  input  logic                            clear_status,
  input  logic                            wifi_iq_ready,
  output logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] wifi_iq_pack,
  output logic                            wifi_iq_valid,
  output logic                            tx_hold,
  output logic                            tx_iq_fifo_empty,
  output logic                            streaming,
  output logic                            overflow_sticky,
  output logic [15:0]                     underrun_cnt
);

  localparam int PW = NUM_CH * 2 * IQ_DATA_WIDTH;
  localparam int XW = IQ_DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic signed [XW-1:0] HALF = XW'(1) <<< (GAIN_SHIFT - 1);
  localparam logic signed [XW-1:0] SMAX = XW'(sat_max(IQ_DATA_WIDTH));
  localparam logic signed [XW-1:0] SMIN = XW'(sat_min(IQ_DATA_WIDTH));

  logic [PW-1:0]    gain_comb;
  logic [PW-1:0]    gain_q;
  logic             wr_en_q;
  logic [PW-1:0]    fifo_head;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic             fifo_drop;
  logic             fifo_pop;
  logic             end_seen;
  logic [PW-1:0]    pack_d;
  tx_state_t        state_q;
  tx_state_t        state_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar k = 0; k < 2; k++) begin : g_part
      localparam int LSB = iq_lsb(c, k, IQ_DATA_WIDTH);
      logic signed [IQ_DATA_WIDTH-1:0] sample;
      logic signed [GAIN_WIDTH-1:0]    gain;
      logic signed [XW-1:0]            prod;
      logic signed [XW-1:0]            rnd;
      logic        [IQ_DATA_WIDTH-1:0] sat;

      assign sample = rf_iq[LSB +: IQ_DATA_WIDTH];
      assign gain   = bb_gain[c*GAIN_WIDTH +: GAIN_WIDTH];

      // one spare bit keeps the rounding add clear of overflow at full-scale products
      always_comb begin
        prod = XW'(sample) * XW'(gain);
        rnd  = (prod + HALF) >>> GAIN_SHIFT;
        if (rnd > SMAX)      sat = SMAX[IQ_DATA_WIDTH-1:0];
        else if (rnd < SMIN) sat = SMIN[IQ_DATA_WIDTH-1:0];
        else                 sat = rnd[IQ_DATA_WIDTH-1:0];
      end

      assign gain_comb[LSB +: IQ_DATA_WIDTH] = sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gain_q  <= '0;
      wr_en_q <= 1'b0;
    end else begin
      gain_q  <= gain_comb;
      wr_en_q <= rf_iq_valid & ~tx_hold;
    end
  end

  tx_iq_mc_fifo #(
    .DATA_WIDTH(PW),
    .ADDR_WIDTH(FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en_q),
    .push_data(gain_q),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .push_drop(fifo_drop)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    pack_d   = wifi_iq_pack;
    unique case (state_q)
      ST_IDLE: begin
        pack_d = '0;
        if (wr_en_q) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        pack_d = '0;
        if (fifo_count >= prefill_thresh || end_seen) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (wifi_iq_ready) begin
          fifo_pop = ~fifo_empty;
          pack_d   = fifo_empty ? '0 : fifo_head;
        end
        // a sample still in the gain register belongs to this packet
        if (fifo_empty && end_seen && !wr_en_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      wifi_iq_pack    <= '0;
      wifi_iq_valid   <= 1'b0;
      end_seen        <= 1'b0;
      tx_hold         <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      state_q       <= state_d;
      wifi_iq_pack  <= pack_d;
      wifi_iq_valid <= 1'b1;
      if (tx_end)                                         end_seen <= 1'b1;
      else if (state_d == ST_IDLE && state_q != ST_IDLE)  end_seen <= 1'b0;
      if (fifo_count >= hold_hi)      tx_hold <= 1'b1;
      else if (fifo_count <= hold_lo) tx_hold <= 1'b0;
      if (fifo_drop)         overflow_sticky <= 1'b1;
      else if (clear_status) overflow_sticky <= 1'b0;
    end
  end

`ifdef TX_IQ_INTF_MC_UNDERRUN_CNT_EN
  logic        underrun_evt;
  logic [15:0] underrun_q;

  assign underrun_evt = (state_q == ST_STREAM) & wifi_iq_ready & fifo_empty & ~end_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= '0;
    end else if (underrun_evt) begin
      if (clear_status)               underrun_q <= 16'd1;
      else if (underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
    end else if (clear_status) begin
      underrun_q <= '0;
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = 16'd0;
`endif

  assign tx_iq_fifo_empty = fifo_empty;
  assign streaming        = (state_q == ST_STREAM);

endmodule

// File: tb/tb_tx_iq_intf_mc.sv
// tb/tb_tx_iq_intf_mc.sv - directed self-checking bench for tx_iq_intf_mc
module tb_tx_iq_intf_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rf_iq;
  logic        rf_iq_valid;
  logic        tx_end;
  logic [19:0] bb_gain;
  logic [9:0]  hold_hi;
  logic [9:0]  hold_lo;
  logic [9:0]  prefill_thresh;
  logic        clear_status;
  logic        wifi_iq_ready;
  logic [63:0] wifi_iq_pack;
  logic        wifi_iq_valid;
  logic        tx_hold;
  logic        tx_iq_fifo_empty;
  logic        streaming;
  logic        overflow_sticky;
  logic [15:0] underrun_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] cap[$];
  logic [63:0] last_cap;
  logic        cap_en;
  logic [15:0] exp_underrun;

  always #5 clk = ~clk;

  tx_iq_intf_mc dut (
    .clk             (clk),
    .rst             (rst),
    .rf_iq           (rf_iq),
    .rf_iq_valid     (rf_iq_valid),
    .tx_end          (tx_end),
    .bb_gain         (bb_gain),
    .hold_hi         (hold_hi),
    .hold_lo         (hold_lo),
    .prefill_thresh  (prefill_thresh),
    .clear_status    (clear_status),
    .wifi_iq_ready   (wifi_iq_ready),
    .wifi_iq_pack    (wifi_iq_pack),
    .wifi_iq_valid   (wifi_iq_valid),
    .tx_hold         (tx_hold),
    .tx_iq_fifo_empty(tx_iq_fifo_empty),
    .streaming       (streaming),
    .overflow_sticky (overflow_sticky),
    .underrun_cnt    (underrun_cnt)
  );

  function automatic logic [63:0] wd(input int k);
    return {16'(k + 4), 16'(k + 3), 16'(k + 2), 16'(k + 1)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (cap_en && wifi_iq_pack != 64'd0 && wifi_iq_pack != last_cap) begin
      cap.push_back(wifi_iq_pack);
      last_cap = wifi_iq_pack;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rf_iq = '0; rf_iq_valid = 1'b0; tx_end = 1'b0; clear_status = 1'b0; wifi_iq_ready = 1'b0;
    bb_gain = {10'd128, 10'd128};
    hold_hi = 10'd500; hold_lo = 10'd100; prefill_thresh = 10'd10;
    cap_en = 1'b0; cap.delete(); last_cap = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
`ifdef TX_IQ_INTF_MC_UNDERRUN_CNT_EN
    exp_underrun = 16'd8;
`else
    exp_underrun = 16'd0;
`endif
    // reset state
    do_reset();
    chk("rst_pack", wifi_iq_pack, 64'd0);
    chk("rst_valid", 64'(wifi_iq_valid), 64'd0);
    chk("rst_hold", 64'(tx_hold), 64'd0);
    chk("rst_empty", 64'(tx_iq_fifo_empty), 64'd1);
    chk("rst_stream", 64'(streaming), 64'd0);
    chk("rst_ovf", 64'(overflow_sticky), 64'd0);
    chk("rst_urun", 64'(underrun_cnt), 64'd0);
    step();
    chk("valid_after_rst", 64'(wifi_iq_valid), 64'd1);

    // 1: unity-gain ramp of 100 words, ends back in IDLE
    wifi_iq_ready = 1'b1; cap_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rf_iq = wd(k); rf_iq_valid = 1'b1; tx_end = (k == 99);
      step();
    end
    rf_iq_valid = 1'b0; tx_end = 1'b0;
    for (int i = 0; i < 300 && streaming; i++) step();
    chk("t1_idle", 64'(streaming), 64'd0);
    chk("t1_nwords", 64'(cap.size()), 64'd100);
    for (int k = 0; k < 100 && k < cap.size(); k++) chk($sformatf("t1_word%0d", k), cap[k], wd(k));
    chk("t1_urun", 64'(underrun_cnt), 64'd0);
    chk("t1_empty", 64'(tx_iq_fifo_empty), 64'd1);
    chk("t1_pack0", wifi_iq_pack, 64'd0);

    // 2: saturation and round-half-up
    do_reset();
    prefill_thresh = 10'd512; wifi_iq_ready = 1'b1; cap_en = 1'b1;
    rf_iq = {16'hFF9C, 16'h8000, 16'd100, 16'h7FFF}; bb_gain = {10'd200, 10'd200}; rf_iq_valid = 1'b1;
    step();
    rf_iq = {16'd1, 16'd5, 16'hFFFD, 16'd3}; bb_gain = {10'd64, 10'd64};
    step();
    rf_iq = {16'h7FFF, 16'h8000, 16'd1, 16'hFFFF}; bb_gain = {10'h200, 10'd64}; tx_end = 1'b1;
    step();
    rf_iq_valid = 1'b0; tx_end = 1'b0;
    for (int i = 0; i < 50; i++) step();
    chk("t2_nwords", 64'(cap.size()), 64'd3);
    if (cap.size() == 3) begin
      chk("t2_sat", cap[0], 64'hFF64_8000_009C_7FFF);
      chk("t2_round", cap[1], 64'h0001_0003_FFFF_0002);
      chk("t2_negsat", cap[2], 64'h8000_7FFF_0001_0000);
    end
    chk("t2_idle", 64'(streaming), 64'd0);

    // 3: hold hysteresis 400/100
    do_reset();
    hold_hi = 10'd400; hold_lo = 10'd100;
    rf_iq = wd(7); rf_iq_valid = 1'b1;
    for (int i = 0; i < 401; i++) step();
    chk("t3_hold_pre", 64'(tx_hold), 64'd0);
    step();
    chk("t3_hold_set", 64'(tx_hold), 64'd1);
    rf_iq_valid = 1'b0;
    repeat (3) step();
    wifi_iq_ready = 1'b1;
    for (int i = 0; i < 302; i++) step();
    chk("t3_hold_keep", 64'(tx_hold), 64'd1);
    step();
    chk("t3_hold_clr", 64'(tx_hold), 64'd0);
    tx_end = 1'b1; step(); tx_end = 1'b0;
    for (int i = 0; i < 200 && streaming; i++) step();
    chk("t3_idle", 64'(streaming), 64'd0);

    // 4: underrun after 60 words with prefill 50
    do_reset();
    prefill_thresh = 10'd50; wifi_iq_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      rf_iq = wd(k); rf_iq_valid = 1'b1;
      step();
    end
    rf_iq_valid = 1'b0;
    repeat (52) step();
    chk("t4_urun0", 64'(underrun_cnt), 64'd0);
    chk("t4_last", wifi_iq_pack, wd(59));
    repeat (8) step();
    chk("t4_urun8", 64'(underrun_cnt), 64'(exp_underrun));
    chk("t4_zero", wifi_iq_pack, 64'd0);
    chk("t4_stream", 64'(streaming), 64'd1);
    wifi_iq_ready = 1'b0;
    step();
    chk("t4_urun_hold", 64'(underrun_cnt), 64'(exp_underrun));

    // 5: overflow at full, clear, push+pop at full
    do_reset();
    hold_hi = 10'd1023; hold_lo = 10'd0; prefill_thresh = 10'd512;
    for (int k = 0; k < 513; k++) begin
      rf_iq = wd(k); rf_iq_valid = 1'b1;
      step();
    end
    rf_iq_valid = 1'b0;
    chk("t5_full", 64'(dut.u_fifo.count), 64'd512);
    chk("t5_ovf_pre", 64'(overflow_sticky), 64'd0);
    step();
    chk("t5_ovf", 64'(overflow_sticky), 64'd1);
    chk("t5_full_kept", 64'(dut.u_fifo.count), 64'd512);
    clear_status = 1'b1; step(); clear_status = 1'b0;
    chk("t5_clr", 64'(overflow_sticky), 64'd0);
    rf_iq = wd(600); rf_iq_valid = 1'b1; step(); rf_iq_valid = 1'b0;
    wifi_iq_ready = 1'b1; step(); wifi_iq_ready = 1'b0;
    chk("t5_pp_count", 64'(dut.u_fifo.count), 64'd512);
    chk("t5_pp_ovf", 64'(overflow_sticky), 64'd0);
    chk("t5_pp_head", wifi_iq_pack, wd(0));

    // 6: async reset mid-STREAM
    wifi_iq_ready = 1'b1;
    repeat (3) step();
    chk("t6_pre_stream", 64'(streaming), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_pack", wifi_iq_pack, 64'd0);
    chk("t6_valid", 64'(wifi_iq_valid), 64'd0);
    chk("t6_empty", 64'(tx_iq_fifo_empty), 64'd1);
    chk("t6_stream", 64'(streaming), 64'd0);
    chk("t6_hold", 64'(tx_hold), 64'd0);
    @(negedge clk);
    wifi_iq_ready = 1'b0;
    rst = 1'b0;
    step();
    chk("t6_valid_back", 64'(wifi_iq_valid), 64'd1);
    chk("t6_still_idle", 64'(streaming), 64'd0);
    chk("t6_count", 64'(dut.u_fifo.count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
